// File: rtl/hazard_pkg.sv
// Opcode constants and decode helpers for the data-hazard scoreboard.
// The pipeline decoder reuses the same functions so both agree on operand usage.
package hazard_pkg;

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_OPIMM  = 5'b00100;
  localparam logic [4:0] OP_OP     = 5'b01100;
  localparam logic [4:0] OP_SYSTEM = 5'b11100;

  typedef struct packed {
    logic rs1;
    logic rs2;
    logic rd;
    logic lng;
  } dec_t;

  // f3 is instr[14]: 0 selects the register form of a CSR op, which reads rs1.
  function automatic logic uses_rs1(input logic [4:0] op, input logic f3);
    return (op == OP_BRANCH) || (op == OP_JALR) || (op == OP_LOAD) ||
           (op == OP_STORE)  || (op == OP_OPIMM) || (op == OP_OP)  ||
           ((op == OP_SYSTEM) && !f3);
  endfunction

  function automatic logic uses_rs2(input logic [4:0] op);
    return (op == OP_BRANCH) || (op == OP_STORE) || (op == OP_OP);
  endfunction

  function automatic logic writes_rd(input logic [4:0] op);
    return !((op == OP_BRANCH) || (op == OP_STORE));
  endfunction

  function automatic dec_t decode(input logic [4:0] op, input logic f3);
    dec_t d;
    d.rs1 = uses_rs1(op, f3);
    d.rs2 = uses_rs2(op);
    d.rd  = writes_rd(op);
    d.lng = (op == OP_LOAD);
    return d;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID/EX/writeback signals seen by the scoreboard, plus its status outputs.
// master = pipeline side, slave = scoreboard side.
interface hazard_scoreboard_if #(
  parameter int DEPTH = 4,
  parameter int RA_W  = 5
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            id_valid;
  logic [4:0]      id_opcode;
  logic            id_funct3;
  logic [RA_W-1:0] id_rs1, id_rs2, id_rd;
  logic            ex_valid, ex_long, ex_advance;
  logic [RA_W-1:0] ex_rd;
  logic            cmpl_valid;
  logic            hazard_stall;
  logic [RA_W-1:0] head_rd;
  logic [CW-1:0]   sb_count;
  logic            sb_full, sb_empty;
  logic            err_overflow, err_underflow;

  modport master (
    output id_valid, id_opcode, id_funct3, id_rs1, id_rs2, id_rd,
           ex_valid, ex_long, ex_rd, ex_advance, cmpl_valid,
    input  hazard_stall, head_rd, sb_count, sb_full, sb_empty,
           err_overflow, err_underflow
  );

  modport slave (
    input  id_valid, id_opcode, id_funct3, id_rs1, id_rs2, id_rd,
           ex_valid, ex_long, ex_rd, ex_advance, cmpl_valid,
    output hazard_stall, head_rd, sb_count, sb_full, sb_empty,
           err_overflow, err_underflow
  );
endinterface

// File: rtl/pending_rd_fifo.sv
// In-order queue of destination registers awaiting long-latency writeback.
// Every entry and its valid bit are exposed so the top can compare in parallel.
module pending_rd_fifo #(
  parameter int DEPTH = 4,
  parameter int RA_W  = 5,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [RA_W-1:0]            i_rd,
  output logic [DEPTH-1:0][RA_W-1:0] o_entries,
  output logic [DEPTH-1:0]           o_vld,
  output logic [RA_W-1:0]            o_head_rd,
  output logic [CW-1:0]              o_count,
  output logic                       o_full,
  output logic                       o_empty,
  output logic                       o_ovf_evt,
  output logic                       o_udf_evt
);
  logic [DEPTH-1:0][RA_W-1:0] r_mem;
  logic [DEPTH-1:0]           r_vld;
  logic [PW-1:0]              r_head, r_tail;
  logic [CW-1:0]              r_count;
  logic                       w_do_push, w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  // A full queue still accepts a push when the head leaves on the same edge.
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_ovf_evt = i_push & o_full & ~w_do_pop;
  assign o_udf_evt = i_pop & o_empty;

  assign o_entries = r_mem;
  assign o_vld     = r_vld;
  assign o_count   = r_count;
  assign o_head_rd = o_empty ? '0 : r_mem[r_head];

  // Pointer/count/storage update; on full push+pop head==tail and the set wins.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      r_mem   <= '0;
      r_vld   <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_pop) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= r_head + PW'(1);
      end
      if (w_do_push) begin
        r_mem[r_tail] <= i_rd;
        r_vld[r_tail] <= 1'b1;
        r_tail        <= r_tail + PW'(1);
      end
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end
endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard unit: stalls ID on RAW/WAW against the EX long op or any
// pending writeback, and on lack of room for another long op.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int RA_W  = 5
) (
  input logic               clk_i,
  input logic               reset_i,
  hazard_scoreboard_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  dec_t                       w_dec;
  logic                       w_ex_long, w_push;
  logic [DEPTH-1:0][RA_W-1:0] w_entries;
  logic [DEPTH-1:0]           w_vld, w_hit1, w_hit2, w_hitd;
  logic [CW-1:0]              w_count;
  logic                       w_full, w_empty, w_ovf_evt, w_udf_evt;
  logic                       w_pend1, w_pend2, w_pendd, w_struct;
  logic                       r_ovf, r_udf;

  assign w_dec     = decode(bus.id_opcode, bus.id_funct3);
  assign w_ex_long = bus.ex_valid & bus.ex_long;
  assign w_push    = w_ex_long & bus.ex_advance & (bus.ex_rd != '0);

  pending_rd_fifo #(.DEPTH(DEPTH), .RA_W(RA_W)) u_fifo (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .i_push    (w_push),
    .i_pop     (bus.cmpl_valid),
    .i_rd      (bus.ex_rd),
    .o_entries (w_entries),
    .o_vld     (w_vld),
    .o_head_rd (bus.head_rd),
    .o_count   (w_count),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_ovf_evt (w_ovf_evt),
    .o_udf_evt (w_udf_evt)
  );

  // Per-entry compare; an entry popping this cycle still matches (no bypass).
  for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
    assign w_hit1[i] = w_vld[i] & (w_entries[i] == bus.id_rs1);
    assign w_hit2[i] = w_vld[i] & (w_entries[i] == bus.id_rs2);
    assign w_hitd[i] = w_vld[i] & (w_entries[i] == bus.id_rd);
  end

  // x0 never creates a dependency.
  assign w_pend1 = (bus.id_rs1 != '0) & ((w_ex_long & (bus.ex_rd == bus.id_rs1)) | (|w_hit1));
  assign w_pend2 = (bus.id_rs2 != '0) & ((w_ex_long & (bus.ex_rd == bus.id_rs2)) | (|w_hit2));
  assign w_pendd = (bus.id_rd  != '0) & ((w_ex_long & (bus.ex_rd == bus.id_rd))  | (|w_hitd));
  assign w_struct = w_dec.lng &
                    (({1'b0, w_count} + (CW+1)'(w_ex_long)) >= (CW+1)'(DEPTH));

  assign bus.hazard_stall = bus.id_valid &
                            ((w_dec.rs1 & w_pend1) | (w_dec.rs2 & w_pend2) |
                             (w_dec.rd & w_pendd) | w_struct);

  assign bus.sb_count      = w_count;
  assign bus.sb_full       = w_full;
  assign bus.sb_empty      = w_empty;
  assign bus.err_overflow  = r_ovf;
  assign bus.err_underflow = r_udf;

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (w_ovf_evt) r_ovf <= 1'b1;
      if (w_udf_evt) r_udf <= 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios plus a randomized run against
// a queue-based reference model of the pending-write list.
module tb_hazard_scoreboard;
  localparam int DEPTH = 4;
  localparam int RA_W  = 5;

  logic clk_i = 1'b0;
  logic reset_i;
  int   vecs = 0;
  int   errs = 0;

  // reference model: pending destinations oldest-first, plus sticky flags
  int q[$];
  bit m_ovf, m_udf;

  always #5 clk_i = ~clk_i;

  hazard_scoreboard_if #(.DEPTH(DEPTH), .RA_W(RA_W)) bus ();

  hazard_scoreboard #(.DEPTH(DEPTH), .RA_W(RA_W)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  task automatic idle();
    bus.id_valid = 0; bus.id_opcode = 0; bus.id_funct3 = 0;
    bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_rd = 0;
    bus.ex_valid = 0; bus.ex_long = 0; bus.ex_rd = 0; bus.ex_advance = 0;
    bus.cmpl_valid = 0;
  endtask

  task automatic set_id(input int op, input int rs1, input int rs2, input int rd);
    bus.id_valid = 1; bus.id_opcode = 5'(op); bus.id_funct3 = 0;
    bus.id_rs1 = 5'(rs1); bus.id_rs2 = 5'(rs2); bus.id_rd = 5'(rd);
  endtask

  task automatic set_ex(input int rd, input bit adv);
    bus.ex_valid = 1; bus.ex_long = 1; bus.ex_rd = 5'(rd); bus.ex_advance = adv;
  endtask

  // Advance one clock; the model applies the inputs seen at that edge.
  task automatic tick();
    bit push;
    @(posedge clk_i);
    if (!reset_i) begin
      q.delete(); m_ovf = 0; m_udf = 0;
    end else begin
      push = bus.ex_valid && bus.ex_long && bus.ex_advance && bus.ex_rd != 0;
      if (bus.cmpl_valid) begin
        if (q.size() == 0) m_udf = 1;
        else void'(q.pop_front());
      end
      if (push) begin
        if (q.size() < DEPTH) q.push_back(int'(bus.ex_rd));
        else m_ovf = 1;
      end
    end
    #1;
  endtask

  function automatic bit pending(input int r);
    if (r == 0) return 0;
    if (bus.ex_valid && bus.ex_long && int'(bus.ex_rd) == r) return 1;
    foreach (q[i]) if (q[i] == r) return 1;
    return 0;
  endfunction

  // Expected stall straight from the operand-usage table and hazard rules.
  function automatic bit exp_stall();
    int op;
    bit u1, u2, wr, lg;
    op = int'(bus.id_opcode);
    u1 = (op == 24) || (op == 25) || (op == 0) || (op == 8) || (op == 4) ||
         (op == 12) || (op == 28 && bus.id_funct3 == 0);
    u2 = (op == 24) || (op == 8) || (op == 12);
    wr = !((op == 24) || (op == 8));
    lg = (op == 0);
    return bus.id_valid &&
           ((u1 && pending(int'(bus.id_rs1))) || (u2 && pending(int'(bus.id_rs2))) ||
            (wr && pending(int'(bus.id_rd))) ||
            (lg && (q.size() + int'(bus.ex_valid && bus.ex_long)) >= DEPTH));
  endfunction

  task automatic do_reset();
    idle();
    reset_i = 0; tick(); tick();
    reset_i = 1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk_i);
    vecs++; if (bus.sb_count !== 0) begin errs++; $display("FAIL rst_count got %0d want 0", bus.sb_count); end
    vecs++; if (bus.sb_empty !== 1'b1) begin errs++; $display("FAIL rst_empty got %b want 1", bus.sb_empty); end
    vecs++; if (bus.sb_full !== 1'b0) begin errs++; $display("FAIL rst_full got %b want 0", bus.sb_full); end
    vecs++; if (bus.head_rd !== 0) begin errs++; $display("FAIL rst_head got %0d want 0", bus.head_rd); end
    vecs++; if (bus.hazard_stall !== 1'b0) begin errs++; $display("FAIL rst_stall got %b want 0", bus.hazard_stall); end
    vecs++; if ({bus.err_overflow, bus.err_underflow} !== 2'b00) begin errs++;
      $display("FAIL rst_err got %b%b want 00", bus.err_overflow, bus.err_underflow); end
  endtask

  task automatic test_load_use();
    idle();
    set_ex(5, 0); set_id(12, 5, 1, 6);
    @(negedge clk_i);
    vecs++; if (bus.hazard_stall !== 1'b1) begin errs++; $display("FAIL load_use got %b want 1", bus.hazard_stall); end
    bus.ex_rd = 0;
    #1;
    vecs++; if (bus.hazard_stall !== 1'b0) begin errs++; $display("FAIL load_use_x0 got %b want 0", bus.hazard_stall); end
    @(posedge clk_i); #1; idle();
  endtask

  task automatic test_pending_raw();
    idle(); set_ex(7, 1); tick(); idle();
    set_id(8, 2, 7, 0);
    for (int c = 0; c < 3; c++) begin
      if (c == 2) bus.cmpl_valid = 1;
      @(negedge clk_i);
      vecs++; if (bus.hazard_stall !== 1'b1) begin errs++; $display("FAIL raw_stall c%0d got %b want 1", c, bus.hazard_stall); end
      vecs++; if (bus.sb_count !== 1) begin errs++; $display("FAIL raw_count c%0d got %0d want 1", c, bus.sb_count); end
      tick(); bus.cmpl_valid = 0;
    end
    @(negedge clk_i);
    vecs++; if (bus.hazard_stall !== 1'b0) begin errs++; $display("FAIL raw_release got %b want 0", bus.hazard_stall); end
    vecs++; if (bus.sb_count !== 0) begin errs++; $display("FAIL raw_count_end got %0d want 0", bus.sb_count); end
    idle();
  endtask

  task automatic test_waw();
    idle(); set_ex(9, 1); tick(); idle();
    set_id(4, 0, 0, 9);
    @(negedge clk_i);
    vecs++; if (bus.hazard_stall !== 1'b1) begin errs++; $display("FAIL waw got %b want 1", bus.hazard_stall); end
    bus.id_rd = 10; #1;
    vecs++; if (bus.hazard_stall !== 1'b0) begin errs++; $display("FAIL waw_other got %b want 0", bus.hazard_stall); end
    @(posedge clk_i); #1;
    idle(); bus.cmpl_valid = 1; tick(); idle();
    @(negedge clk_i);
    vecs++; if (bus.sb_empty !== 1'b1) begin errs++; $display("FAIL waw_drain got %b want 1", bus.sb_empty); end
  endtask

  task automatic test_full();
    idle();
    for (int r = 1; r <= 4; r++) begin set_ex(r, 1); tick(); end
    idle(); set_id(0, 20, 0, 21);
    @(negedge clk_i);
    vecs++; if (bus.sb_full !== 1'b1) begin errs++; $display("FAIL full_flag got %b want 1", bus.sb_full); end
    vecs++; if (bus.hazard_stall !== 1'b1) begin errs++; $display("FAIL full_struct got %b want 1", bus.hazard_stall); end
    vecs++; if (bus.head_rd !== 1) begin errs++; $display("FAIL full_head got %0d want 1", bus.head_rd); end
    @(posedge clk_i); #1;
    idle(); set_ex(5, 1); bus.cmpl_valid = 1; tick(); idle();
    @(negedge clk_i);
    vecs++; if (bus.sb_count !== 4) begin errs++; $display("FAIL full_pushpop_count got %0d want 4", bus.sb_count); end
    vecs++; if (bus.head_rd !== 2) begin errs++; $display("FAIL full_pushpop_head got %0d want 2", bus.head_rd); end
    vecs++; if (bus.err_overflow !== 1'b0) begin errs++; $display("FAIL full_no_ovf got %b want 0", bus.err_overflow); end
    @(posedge clk_i); #1;
    set_ex(6, 1); tick(); idle();
    @(negedge clk_i);
    vecs++; if (bus.err_overflow !== 1'b1) begin errs++; $display("FAIL ovf got %b want 1", bus.err_overflow); end
    vecs++; if (bus.sb_count !== 4) begin errs++; $display("FAIL ovf_count got %0d want 4", bus.sb_count); end
  endtask

  task automatic test_underflow_wrap();
    do_reset();
    bus.cmpl_valid = 1; tick(); idle();
    @(negedge clk_i);
    vecs++; if (bus.err_underflow !== 1'b1) begin errs++; $display("FAIL udf got %b want 1", bus.err_underflow); end
    vecs++; if (bus.sb_count !== 0) begin errs++; $display("FAIL udf_count got %0d want 0", bus.sb_count); end
    @(posedge clk_i); #1;
    set_ex(11, 1); tick();
    for (int k = 0; k < 10; k++) begin
      set_ex(12 + k, 1); bus.cmpl_valid = 1;
      @(negedge clk_i);
      vecs++; if (bus.head_rd !== 5'(11 + k)) begin errs++; $display("FAIL wrap_head k%0d got %0d want %0d", k, bus.head_rd, 11 + k); end
      tick();
    end
    idle();
    @(negedge clk_i);
    vecs++; if (bus.head_rd !== 21 || bus.sb_count !== 1) begin errs++;
      $display("FAIL wrap_end got head %0d count %0d want 21/1", bus.head_rd, bus.sb_count); end
    @(posedge clk_i); #1;
    bus.cmpl_valid = 1; tick(); idle();
  endtask

  task automatic test_reset_mid();
    idle();
    for (int r = 3; r <= 5; r++) begin set_ex(r, 1); tick(); end
    idle(); set_id(12, 3, 0, 6);
    @(negedge clk_i);
    vecs++; if (bus.hazard_stall !== 1'b1 || bus.sb_count !== 3) begin errs++;
      $display("FAIL mid_pre got stall %b count %0d want 1/3", bus.hazard_stall, bus.sb_count); end
    @(posedge clk_i); #1;
    set_ex(8, 1); bus.cmpl_valid = 1; reset_i = 0;
    tick();
    reset_i = 1; bus.ex_valid = 0; bus.ex_long = 0; bus.ex_advance = 0; bus.cmpl_valid = 0;
    @(negedge clk_i);
    vecs++; if (bus.sb_count !== 0 || bus.sb_empty !== 1'b1) begin errs++;
      $display("FAIL mid_count got %0d empty %b want 0/1", bus.sb_count, bus.sb_empty); end
    vecs++; if ({bus.err_overflow, bus.err_underflow} !== 2'b00) begin errs++;
      $display("FAIL mid_err got %b%b want 00", bus.err_overflow, bus.err_underflow); end
    vecs++; if (bus.hazard_stall !== 1'b0) begin errs++; $display("FAIL mid_stall got %b want 0", bus.hazard_stall); end
    @(posedge clk_i); #1; idle();
  endtask

  task automatic test_random();
    int ops[8] = '{0, 8, 24, 25, 4, 12, 28, 3};
    int hd;
    for (int n = 0; n < 600; n++) begin
      reset_i = ($urandom_range(0, 39) != 0);
      bus.id_valid  = $urandom_range(0, 3) != 0;
      bus.id_opcode = 5'(ops[$urandom_range(0, 7)]);
      bus.id_funct3 = 1'($urandom_range(0, 1));
      bus.id_rs1 = 5'($urandom_range(0, 7));
      bus.id_rs2 = 5'($urandom_range(0, 7));
      bus.id_rd  = 5'($urandom_range(0, 7));
      bus.ex_valid   = $urandom_range(0, 3) != 0;
      bus.ex_long    = 1'($urandom_range(0, 1));
      bus.ex_rd      = 5'($urandom_range(0, 7));
      bus.ex_advance = 1'($urandom_range(0, 1));
      bus.cmpl_valid = $urandom_range(0, 2) == 0;
      @(negedge clk_i);
      hd = (q.size() != 0) ? q[0] : 0;
      vecs++; if (bus.hazard_stall !== exp_stall()) begin errs++;
        $display("FAIL rnd_stall n%0d got %b want %b", n, bus.hazard_stall, exp_stall()); end
      vecs++; if (bus.sb_count !== 3'(q.size()) || bus.head_rd !== 5'(hd)) begin errs++;
        $display("FAIL rnd_queue n%0d got count %0d head %0d want %0d/%0d", n, bus.sb_count, bus.head_rd, q.size(), hd); end
      vecs++; if (bus.sb_full !== (q.size() == DEPTH) || bus.sb_empty !== (q.size() == 0)) begin errs++;
        $display("FAIL rnd_flags n%0d got full %b empty %b size %0d", n, bus.sb_full, bus.sb_empty, q.size()); end
      vecs++; if (bus.err_overflow !== m_ovf || bus.err_underflow !== m_udf) begin errs++;
        $display("FAIL rnd_err n%0d got %b%b want %b%b", n, bus.err_overflow, bus.err_underflow, m_ovf, m_udf); end
      tick();
    end
    reset_i = 1; idle();
  endtask

  initial begin
    reset_i = 0;
    idle();
    test_reset();
    test_load_use();
    test_pending_raw();
    test_waw();
    test_full();
    test_underflow_wrap();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised data-hazard unit for the decode stage, replacing single-load-in-EX stall logic with a scoreboard of outstanding long-latency register writes. Loads and other variable-latency ops leave EX, sit in an in-order pending queue until their writeback completes, and any ID instruction that reads or rewrites a pending destination is stalled. The block also handles the classic load-use case against EX, ignores x0, and flags queue overflow and underflow.

## Interface
Parameters:
- DEPTH, 4: max outstanding long-latency writes (≥2, power of two).
- RA_W, 5: register-address width.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- reset_i  in  1  synchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_opcode  in  5  instr[6:2] of the ID instruction.
- id_funct3  in  1  instr[14] (CSR immediate vs register form).
- id_rs1, id_rs2, id_rd  in  RA_W  ID source and destination addresses.
- ex_valid  in  1  EX holds a real instruction.
- ex_long  in  1  EX instruction is long-latency (load or multi-cycle op).
- ex_rd  in  RA_W  EX destination.
- ex_advance  in  1  EX instruction moves to MEM this cycle.
- cmpl_valid  in  1  oldest pending op writes back this cycle.
- hazard_stall  out  1  freeze PC/IF/ID and bubble EX.
- head_rd  out  RA_W  destination of the oldest pending entry (writeback steering).
- sb_count  out  $clog2(DEPTH)+1  number of valid entries.
- sb_full, sb_empty  out  1  count==DEPTH / count==0.
- err_overflow, err_underflow  out  1  sticky error flags.

## Operation
- Decode: uses_rs1 for opcodes 1100x, 00000, 01000, 00100, 01100, and 11100 with funct3==0; uses_rs2 for 11000, 01000, 01100; writes_rd for all except 11000, 01000; is_long for 00000. Any rs/rd equal to 0 never matches.
- Push: ex_valid & ex_long & ex_advance & ex_rd≠0 writes ex_rd at the tail.
- Pop: cmpl_valid removes the head. Completions are strictly in order.
- Push and pop in the same cycle: both happen, so the count is unchanged. This is legal even when full.
- Push when full without pop: entry dropped, err_overflow set.
- Pop when empty: ignored, err_underflow set. Both error flags clear only on reset.
- hazard_stall = id_valid & (RAW | WAW | STRUCT):
  - RAW: a used rs matches ex_rd (while ex_valid & ex_long) or matches any valid entry.
  - WAW: writes_rd & id_rd matches the same set.
  - STRUCT: is_long & (sb_count + (ex_valid & ex_long)) ≥ DEPTH.
- An entry popping this cycle still counts as a match; there is no completion bypass.
- Reset clears pointers, count, and flags. Entries in flight are discarded, and memory must be quiesced by the same reset.

## Timing
- hazard_stall, head_rd, and the flags are combinational from the inputs and registered state, with zero-cycle latency to ID.
- Push and pop take effect at the next edge, so a matching stall releases one cycle after cmpl_valid.
- Pointers wrap modulo DEPTH.
- Reset values: hazard_stall=0 (given id_valid=0), sb_count=0, sb_empty=1, sb_full=0, head_rd=0, err_*=0.
- Reset asserted mid-operation wins over a simultaneous push or pop.

## Structure
- Shared package hazard_pkg holds the opcode constants (OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR, OP_OPIMM, OP_OP, OP_SYSTEM) and the decode functions uses_rs1/uses_rs2/writes_rd. The pipeline decoder reuses them.
- One sub-module, pending_rd_fifo, provides DEPTH×RA_W storage with head/tail/count and per-entry valid vector exposed for parallel compare. The top level holds the match and stall logic.

## Test plan
- Load-use: EX load x5 (ex_long=1), ID add x6,x5,x1 → hazard_stall=1. Same with rd=x0 → 0.
- Pending RAW: push x7, no completion for 3 cycles, ID sw x7 → stall for 3 cycles. cmpl_valid on cycle 3 → stall low on cycle 4, sb_count 1→0.
- WAW: pending x9, ID addi x9,x0,1 → stall. ID addi x10 → no stall.
- Full / structural (DEPTH=4): push x1..x4 → sb_full=1. ID load → stall. Simultaneous push x5 and pop → count stays 4, head_rd=x2. Push without pop → err_overflow=1.
- Underflow/wrap: pop on empty → err_underflow=1, count stays 0. Then 10 push/pop pairs → head_rd tracks order across the wrap.
- Reset mid-run: 3 entries pending, reset_i=0 for one edge → count=0, flags=0, no stall on a previously matching ID.
